// File: rtl/usb_audio_stream.sv
// usb_audio_stream
//   Isochronous playback stream controller. Collects endpoint-1 OUT payload
//   bytes, assembles 16-bit stereo frames (byte order L[7:0], L[15:8],
//   R[7:0], R[15:8]), buffers them in an internal FIFO and releases one frame
//   per sample strobe. Sequences STOP -> PRIME -> PLAY and recovers from
//   underflow by re-priming.
//
// Parameters
//   DEPTH_LOG2 : FIFO depth is 2^DEPTH_LOG2 stereo frames
//   PRIME      : frames required before playback starts/resumes (1..2^DEPTH_LOG2)
//
// Ports
//   Clk, nReset (sync, active low)
//   Enable        streaming alternate setting selected (low = stream closed)
//   Mute          force outputs to zero, FIFO still consumed
//   Endpoint, OUT_SoP, OUT_EoP, OUT_Valid, OUT_Data   transceiver OUT port
//   Sample_Strobe one-cycle sample tick
//   Left, Right   output samples, Sample_Valid pulses when they update
//   Level         FIFO occupancy, Playing = state PLAY
//   Overflow      pulse when a complete frame is dropped (FIFO full)
//   Underflow     pulse when a PLAY strobe finds the FIFO empty
//
// Configuration macro
//   AUDIO_STREAM_HOLD_EN : on underflow, and on the PRIME strobes following
//   it, repeat the last popped frame instead of zero.
module usb_audio_stream #(
  parameter int DEPTH_LOG2 = 8,
  parameter int PRIME      = 128
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  Enable,
  input  logic                  Mute,
  input  logic [3:0]            Endpoint,
  input  logic                  OUT_SoP,
  input  logic                  OUT_EoP,
  input  logic                  OUT_Valid,
  input  logic [7:0]            OUT_Data,
  input  logic                  Sample_Strobe,
  output logic [15:0]           Left,
  output logic [15:0]           Right,
  output logic                  Sample_Valid,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  Playing,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         FULL_LVL  = LW'(1 << DEPTH_LOG2);
  localparam logic [LW-1:0]         PRIME_LVL = LW'(PRIME);
  localparam logic [LW-1:0]         LVL_ONE   = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]            idx_reg;
  logic [1:0]            idx_cur;
  logic [7:0]            b0_reg, b1_reg, b2_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         level_reg;
  logic [31:0]           mem [1 << DEPTH_LOG2];
  logic [31:0]           rd_data_reg;
  logic                  out_fifo_reg;
  logic                  valid_reg, ovf_reg, unf_reg;
`ifdef AUDIO_STREAM_HOLD_EN
  logic                  has_pop_reg;
`endif

  logic accept, frame_done, wr_en, strobe_play, pop, underrun;

  assign accept      = OUT_Valid & ~OUT_EoP & (Endpoint == 4'd1) & Enable;
  // The SoP beat itself is byte 0 of the packet, so the index restart must
  // apply combinationally to the byte arriving with it.
  assign idx_cur     = OUT_SoP ? 2'd0 : idx_reg;
  assign frame_done  = accept & (idx_cur == 2'd3);
  // Full check uses the pre-pop level, so a simultaneous pop never frees a slot.
  assign wr_en       = frame_done & (level_reg != FULL_LVL);
  assign strobe_play = Enable & Sample_Strobe & (state_reg == ST_PLAY);
  assign pop         = strobe_play & (level_reg != '0);
  assign underrun    = strobe_play & (level_reg == '0);

  // ---------------- state machine ----------------
  always_ff @(posedge Clk) begin
    if (!nReset) state_reg <= ST_STOP;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOP:  if (Enable) state_next = ST_PRIME;
      ST_PRIME: if (level_reg >= PRIME_LVL) state_next = ST_PLAY;
      ST_PLAY:  if (underrun) state_next = ST_PRIME;
      default:  state_next = ST_STOP;
    endcase
    if (!Enable) state_next = ST_STOP;
  end

  // ---------------- byte assembly data ----------------
  always_ff @(posedge Clk) begin
    if (accept) begin
      case (idx_cur)
        2'd0:    b0_reg <= OUT_Data;
        2'd1:    b1_reg <= OUT_Data;
        2'd2:    b2_reg <= OUT_Data;
        default: ;
      endcase
    end
  end

  // ---------------- FIFO storage (registered read) ----------------
  // rd_data_reg only changes on a pop, so it doubles as the last popped frame.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {b1_reg, b0_reg, OUT_Data, b2_reg};
    if (pop)   rd_data_reg     <= mem[rd_ptr_reg];
  end

  // ---------------- control / pointers / outputs ----------------
  always_ff @(posedge Clk) begin
    if (!nReset || !Enable) begin
      idx_reg      <= 2'd0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      out_fifo_reg <= 1'b0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
`ifdef AUDIO_STREAM_HOLD_EN
      has_pop_reg  <= 1'b0;
`endif
    end else begin
      valid_reg <= Sample_Strobe & (state_reg != ST_STOP);
      ovf_reg   <= frame_done & ~wr_en;
      unf_reg   <= underrun;

      if (OUT_EoP)      idx_reg <= 2'd0;
      else if (accept)  idx_reg <= idx_cur + 2'd1;
      else if (OUT_SoP) idx_reg <= 2'd0;

      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: ;
      endcase

`ifdef AUDIO_STREAM_HOLD_EN
      if (pop) has_pop_reg <= 1'b1;
`endif

      // Output source select: FIFO read data or zero. Only updated on a
      // strobe so values hold between samples.
      if (Sample_Strobe && state_reg != ST_STOP) begin
        if (pop) begin
          out_fifo_reg <= ~Mute;
        end else begin
`ifdef AUDIO_STREAM_HOLD_EN
          // Before any pop since STOP there is nothing to hold; this makes
          // the initial PRIME phase output zeros.
          out_fifo_reg <= ~Mute & has_pop_reg;
`else
          out_fifo_reg <= 1'b0;
`endif
        end
      end
    end
  end

  assign Left         = out_fifo_reg ? rd_data_reg[31:16] : 16'd0;
  assign Right        = out_fifo_reg ? rd_data_reg[15:0]  : 16'd0;
  assign Sample_Valid = valid_reg;
  assign Level        = level_reg;
  assign Playing      = (state_reg == ST_PLAY);
  assign Overflow     = ovf_reg;
  assign Underflow    = unf_reg;

endmodule
